// File: rtl/alu_seq.sv
// Registered, valid/ready handshaked ALU with condition flags and bit-serial shifts.
// Define ALU_SEQ_MUL_EN to enable the shift-add unsigned multiply on opcode 10.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             out_wb,
  output logic             out_illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0]   CNT_ONE = (SHW+1)'(1);
  localparam logic [WIDTH:0] SUM_ONE = (WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_next;
  logic [3:0]       op, op_next;
  logic [WIDTH-1:0] work_lo, work_lo_next;
  logic [SHW:0]     cnt, cnt_next;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] work_hi, work_hi_next;
  logic [WIDTH-1:0] work_b, work_b_next;
  logic [WIDTH:0]   mul_sum;
`endif

  logic             load;
  logic [WIDTH-1:0] fin_result;
  logic             fin_carry, fin_ovf, fin_wb, fin_illegal;
  logic [WIDTH:0]   add_sum, sub_sum;

  always_comb begin
    add_sum      = {1'b0, in_a} + {1'b0, in_b};
    sub_sum      = {1'b0, in_a} + {1'b0, ~in_b} + SUM_ONE;
    state_next   = state;
    op_next      = op;
    work_lo_next = work_lo;
    cnt_next     = cnt;
`ifdef ALU_SEQ_MUL_EN
    work_hi_next = work_hi;
    work_b_next  = work_b;
    mul_sum      = '0;
`endif
    load         = 1'b0;
    fin_result   = '0;
    fin_carry    = 1'b0;
    fin_ovf      = 1'b0;
    fin_wb       = 1'b0;
    fin_illegal  = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          op_next    = in_op;
          load       = 1'b1;
          fin_wb     = 1'b1;
          state_next = DONE;
          case (in_op)
            4'd0: begin
              fin_result = add_sum[WIDTH-1:0];
              fin_carry  = add_sum[WIDTH];
              fin_ovf    = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                           (add_sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            4'd1, 4'd6: begin
              fin_result = sub_sum[WIDTH-1:0];
              fin_carry  = sub_sum[WIDTH];
              fin_ovf    = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                           (sub_sum[WIDTH-1] != in_a[WIDTH-1]);
              fin_wb     = (in_op == 4'd1);
            end
            4'd2: fin_result = in_a & in_b;
            4'd3: fin_result = in_a | in_b;
            4'd4: fin_result = in_a ^ in_b;
            4'd5: fin_result = ~in_a;
            4'd7, 4'd8, 4'd9: begin
              // A zero shift amount completes immediately with carry 0.
              fin_result = in_a;
              if (in_b[SHW-1:0] != '0) begin
                load         = 1'b0;
                state_next   = EXEC;
                work_lo_next = in_a;
                cnt_next     = {1'b0, in_b[SHW-1:0]};
              end
            end
`ifdef ALU_SEQ_MUL_EN
            4'd10: begin
              load         = 1'b0;
              state_next   = EXEC;
              work_lo_next = in_a;
              work_b_next  = in_b;
              work_hi_next = '0;
              cnt_next     = (SHW+1)'(WIDTH);
            end
`endif
            default: begin
              fin_wb      = 1'b0;
              fin_illegal = 1'b1;
            end
          endcase
        end
      end
      EXEC: begin
        cnt_next = cnt - CNT_ONE;
        case (op)
          4'd7: begin
            work_lo_next = {work_lo[WIDTH-2:0], 1'b0};
            fin_carry    = work_lo[WIDTH-1];
          end
          4'd8: begin
            work_lo_next = {1'b0, work_lo[WIDTH-1:1]};
            fin_carry    = work_lo[0];
          end
          4'd9: begin
            work_lo_next = {work_lo[WIDTH-1], work_lo[WIDTH-1:1]};
            fin_carry    = work_lo[0];
          end
`ifdef ALU_SEQ_MUL_EN
          4'd10: begin
            // Conditionally add multiplicand into the high half, then shift {carry,hi,lo} right.
            mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, work_b} : '0);
            {work_hi_next, work_lo_next} = {mul_sum, work_lo[WIDTH-1:1]};
            fin_carry = (work_hi_next != '0);
          end
`endif
          default: ;
        endcase
        fin_result = work_lo_next;
        fin_wb     = 1'b1;
        if (cnt == CNT_ONE) begin
          load       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op          <= '0;
      work_lo     <= '0;
      cnt         <= '0;
`ifdef ALU_SEQ_MUL_EN
      work_hi     <= '0;
      work_b      <= '0;
`endif
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_carry   <= 1'b0;
      out_zero    <= 1'b0;
      out_neg     <= 1'b0;
      out_ovf     <= 1'b0;
      out_wb      <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      state    <= state_next;
      op       <= op_next;
      work_lo  <= work_lo_next;
      cnt      <= cnt_next;
`ifdef ALU_SEQ_MUL_EN
      work_hi  <= work_hi_next;
      work_b   <= work_b_next;
`endif
      in_ready <= (state_next == IDLE);
      if (load) begin
        out_valid   <= 1'b1;
        out_result  <= fin_result;
        out_carry   <= fin_carry;
        out_zero    <= (fin_result == '0);
        out_neg     <= fin_result[WIDTH-1];
        out_ovf     <= fin_ovf;
        out_wb      <= fin_wb;
        out_illegal <= fin_illegal;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq (WIDTH=16) against a behavioural model.
// Honors ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_carry, out_zero, out_neg, out_ovf, out_wb, out_illegal;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
    .out_wb(out_wb), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] r;
    logic c, z, n, v, wb, ill;
    int lat;
    int exp_cyc;
    int hold;
    bit seen;
  } exp_t;

  exp_t q[$];

  // Expected outcome of one operation, from plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    longint ua, ub, sa, sb, s, full;
    int n;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    n = int'(b[3:0]);
    e = '{default: 0};
    e.lat = 1;
    e.wb  = 1'b1;
    case (op)
      4'd0: begin
        full = ua + ub; e.r = full[15:0]; e.c = full[16];
        s = sa + sb; e.v = (s > 32767) || (s < -32768);
      end
      4'd1, 4'd6: begin
        full = ua + (ub ^ 64'hFFFF) + 1; e.r = full[15:0]; e.c = full[16];
        s = sa - sb; e.v = (s > 32767) || (s < -32768);
        e.wb = (op == 4'd1);
      end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: e.r = a ^ b;
      4'd5: e.r = ~a;
      4'd7: begin
        full = ua << n; e.r = full[15:0]; e.c = (n != 0) && full[16]; e.lat = 1 + n;
      end
      4'd8: begin
        e.r = a >> n; if (n != 0) e.c = a[n-1]; e.lat = 1 + n;
      end
      4'd9: begin
        e.r = 16'($signed(a) >>> n); if (n != 0) e.c = a[n-1]; e.lat = 1 + n;
      end
`ifdef ALU_SEQ_MUL_EN
      4'd10: begin
        full = ua * ub; e.r = full[15:0]; e.c = (full[31:16] != 0); e.lat = 17;
      end
`endif
      default: begin
        e.r = 16'h0; e.wb = 1'b0; e.ill = 1'b1;
      end
    endcase
    e.z = (e.r == 16'h0);
    e.n = e.r[15];
    return e;
  endfunction

  function automatic logic [29:0] mk(input logic [15:0] r, input logic c, input logic z,
                                     input logic n, input logic v, input logic wb,
                                     input logic ill, input int lat);
    return {r, c, z, n, v, wb, ill, lat[7:0]};
  endfunction

  function automatic logic [29:0] pack(input exp_t e);
    return mk(e.r, e.c, e.z, e.n, e.v, e.wb, e.ill, e.lat);
  endfunction

  task automatic pin(input string name, input exp_t e, input logic [29:0] req);
    tests++;
    if (pack(e) !== req) begin
      fails++;
      $display("FAIL model_%s got=%h required=%h", name, pack(e), req);
    end
  endtask

  // Compare process: pins the model, then checks DUT outputs on every falling edge.
  initial begin
    exp_t e;
    bit was_rst;
    logic [22:0] got, want;
    was_rst = 1'b0;
    out_ready = 1'b0;
    pin("add_wrap", model(4'd0, 16'hFFFF, 16'h0001), mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1));
    pin("add_ovf",  model(4'd0, 16'h7FFF, 16'h0001), mk(16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1));
    pin("cmp",      model(4'd6, 16'h0005, 16'h0007), mk(16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    pin("asr",      model(4'd9, 16'h8000, 16'h0003), mk(16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4));
    pin("shl",      model(4'd7, 16'h8001, 16'h0001), mk(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2));
`ifdef ALU_SEQ_MUL_EN
    pin("mul",      model(4'd10, 16'h0100, 16'h0100), mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 17));
`else
    pin("mul",      model(4'd10, 16'h0100, 16'h0100), mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1));
`endif
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tests++;
        got = {out_valid, out_result, out_carry, out_zero, out_neg, out_ovf, out_wb, out_illegal};
        if (got !== 23'h0) begin
          fails++;
          $display("FAIL reset_outputs got=%h required=0", got);
        end
        q.delete();
        was_rst = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        if (was_rst) begin
          tests++;
          if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
          end
          was_rst = 1'b0;
        end
        if (out_valid) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL spurious_valid got=1 required=0 cycle=%0d", cyc);
            out_ready = 1'b1;
          end else begin
            e = q[0];
            got  = {1'b0, out_result, out_carry, out_zero, out_neg, out_ovf, out_wb, out_illegal};
            want = {1'b0, e.r, e.c, e.z, e.n, e.v, e.wb, e.ill};
            if (got !== want) begin
              fails++;
              $display("FAIL result_flags got=%h required=%h cycle=%0d", got, want, cyc);
            end
            if (!e.seen) begin
              tests++;
              if (cyc != e.exp_cyc) begin
                fails++;
                $display("FAIL latency got=cycle %0d required=cycle %0d", cyc, e.exp_cyc);
              end
              q[0].seen = 1'b1;
            end
            tests++;
            if (in_ready !== 1'b0) begin
              fails++;
              $display("FAIL busy_in_ready got=%b required=0", in_ready);
            end
            if (q[0].hold > 0) begin
              out_ready = 1'b0;
              q[0].hold = q[0].hold - 1;
            end else begin
              out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_ready) void'(q.pop_front());
          end
        end else begin
          out_ready = 1'($urandom_range(0, 1));
          if (q.size() > 0 && !q[0].seen && cyc > q[0].exp_cyc) begin
            tests++;
            fails++;
            $display("FAIL late_valid got=0 required=1 at cycle %0d", q[0].exp_cyc);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // Present one operation once in_ready is seen; while busy, drive ignored garbage.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
    exp_t e;
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && rst_n === 1'b1) break;
      in_valid = 1'($urandom_range(0, 1));
      in_op = 4'($urandom);
      in_a = 16'($urandom);
      in_b = 16'($urandom);
    end
    if (k == 200) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout got=0 required=1");
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    e = model(op, a, b);
    e.exp_cyc = cyc + e.lat;
    e.hold = hold;
    e.seen = 1'b0;
    q.push_back(e);
    $display("[TB] op=%0d a=%h b=%h expect r=%h c=%b z=%b n=%b v=%b wb=%b ill=%b lat=%0d",
             op, a, b, e.r, e.c, e.z, e.n, e.v, e.wb, e.ill, e.lat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int k;
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_op = 4'd0;
    in_a = 16'h0;
    in_b = 16'h0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    send(4'd0, 16'hFFFF, 16'h0001, 0);
    send(4'd0, 16'h7FFF, 16'h0001, 0);
    send(4'd6, 16'h0005, 16'h0007, 0);
    send(4'd9, 16'h8000, 16'h0003, 0);
    send(4'd7, 16'h8001, 16'h0001, 0);
    send(4'd0, 16'h1234, 16'h1111, 5);
    send(4'd10, 16'h0100, 16'h0100, 0);
    send(4'd7, 16'h1234, 16'h0000, 0);
    send(4'd13, 16'hFFFF, 16'hFFFF, 0);
    send(4'd8, 16'h8000, 16'h0004, 0);

    // Reset asserted in the middle of a 15-bit shift.
    send(4'd7, 16'hA5A5, 16'h000F, 0);
    idle(6);
    #1 rst_n = 1'b0;
    idle(2);
    #1 rst_n = 1'b1;
    send(4'd0, 16'h0003, 16'h0004, 0);

    for (int i = 0; i < 400; i++) begin
      send(4'($urandom_range(0, 15)), pick(), pick(),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0);
    end

    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (q.size() == 0) break;
    end
    if (k == 300) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got=%0d pending required=0", q.size());
    end
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
